ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/ram_reader_pkg.sv | 13 +
 rtl/ram_reader_fifo.sv | 48 ++++
 rtl/ram_reader.sv | 124 ++++++++++++
 tb/tb_ram_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM encoding and prefetch FIFO sizing.
package ram_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ram_reader_fifo.sv
// Two-entry FIFO between the RAM read port and the output stream.
module ram_reader_fifo
  import ram_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam logic [FIFO_CNT_W-1:0] FullCnt = FIFO_CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    // A full FIFO can still accept a push in the same cycle it pops.
    do_push = push && ((count_q != FullCnt) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ram_reader.sv
// Burst reader: fetches `length` words from a 1-cycle-latency RAM starting at base_addr
// and streams them out with valid/ready, prefetching through a 2-entry FIFO.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_req,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]      out_idx_q;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic                  issue, latch, pop;
  logic [OCC_W-1:0]      occ;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  ram_reader_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(ram_read_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Words held or owed to the FIFO once this cycle's pop is taken out.
  assign occ = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;
    latch       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            latch   = 1'b1;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (occ < OCC_W'(FIFO_DEPTH)) begin
          issue       = 1'b1;
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
          if (issue_cnt_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_idx_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= done_d;
      if (latch) begin
        base_q      <= base_addr;
        len_q       <= length;
        issue_cnt_q <= '0;
        out_idx_q   <= '0;
      end else begin
        issue_cnt_q <= issue_cnt_d;
        if (pop) out_idx_q <= out_idx_q + LEN_W'(1);
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ram_read_req  = issue;
  assign ram_read_addr = issue ? (base_q + issue_cnt_q[ADDR_WIDTH-1:0]) : '0;
  assign out_data      = out_valid ? fifo_head : '0;
  assign out_last      = out_valid && (out_idx_q == (len_q - LEN_W'(1)));

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: table of bursts plus reset/abort corner sequences.
module tb_ram_reader;

  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_read_req, out_valid, out_last;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;

  ram_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .ram_read_req (ram_read_req),
    .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  // External RAM with registered read.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) if (ram_read_req) ram_read_data <= mem[ram_read_addr];

  int cyc = 0;
  int cyc0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // Monitor state (written only by the monitor process).
  logic [DW-1:0] rx_data[$];
  bit            rx_last[$];
  int            rx_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            busy_at_done = 0;
  int            busy_c1 = 0;
  int            max_occ = 0;
  int            stall_bad = 0;
  int            stall_seen = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (stall_prev && out_valid) begin
      stall_seen++;
      if (out_data !== stall_data) stall_bad++;
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      rx_cyc.push_back(cyc - cyc0);
    end
    if (ram_read_req) rd_addr.push_back(ram_read_addr);
    if (done) begin
      done_cnt++;
      done_cyc = cyc - cyc0;
      busy_at_done = int'(busy);
    end
    if (cyc - cyc0 == 1) busy_c1 = int'(busy);
    if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_req"}, int'(ram_read_req), 0);
    chk({tag, "_addr"}, int'(ram_read_addr), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_last"}, int'(out_last), 0);
    chk({tag, "_data"}, int'(out_data), 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    bit            toggle;
    int            repulse;    // relative cycle of a stray start, 0 = none
    int            exp_first;  // -1 = not checked
    int            exp_done;   // -1 = not checked
  } vec_t;

  task automatic run_burst(input vec_t v);
    int rx0, rd0, dc0, sh0, ss0, k, n;
    bit fin;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    rx0 = rx_data.size();
    rd0 = rd_addr.size();
    dc0 = done_cnt;
    sh0 = stall_bad;
    ss0 = stall_seen;
    cyc0 = cyc;
    start = 1'b1;
    base_addr = v.base;
    length = v.len[AW:0];
    out_ready = 1'b1;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      k++;
      start = (k == v.repulse);
      if (start) begin
        base_addr = v.base ^ 12'h5A5;
        length = 13'd2;
      end
      if (v.toggle) out_ready = ~out_ready;
      if (done_cnt != dc0) fin = 1'b1;
      else if (k > v.len * 3 + 20) begin
        chk("done_timeout", 0, 1);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt - dc0, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("busy_cycle1", busy_c1, int'(v.len > 0));
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    chk("word_count", rx_data.size() - rx0, v.len);
    chk("read_count", rd_addr.size() - rd0, v.len);
    if (v.exp_first >= 0 && rx_data.size() > rx0) chk("first_cycle", rx_cyc[rx0], v.exp_first);
    n = v.len;
    if (rx_data.size() - rx0 < n) n = rx_data.size() - rx0;
    for (int i = 0; i < n; i++) begin
      a = v.base + AW'(i);
      chk("word_data", int'(rx_data[rx0 + i]), int'(mem[a]));
      chk("word_last", int'(rx_last[rx0 + i]), int'(i == v.len - 1));
    end
    n = v.len;
    if (rd_addr.size() - rd0 < n) n = rd_addr.size() - rd0;
    for (int i = 0; i < n; i++) begin
      a = v.base + AW'(i);
      chk("read_addr", int'(rd_addr[rd0 + i]), int'(a));
    end
    chk("stall_hold", stall_bad - sh0, 0);
    if (v.toggle) chk("stalls_seen", int'(stall_seen > ss0), 1);
    chk("fifo_max_le2", int'(max_occ <= 2), 1);
  endtask

  vec_t vecs[8];

  initial begin
    int rx0, dc0, late;
    vec_t clean;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'((i * 37 + (i >> 5)) ^ 8'h5A);
    mem[12'h010] = 8'hA1;
    mem[12'h011] = 8'hB2;
    mem[12'h012] = 8'hC3;
    mem[12'h013] = 8'hD4;

    vecs[0] = '{12'h010, 4, 1'b0, 0, 3, 7};
    vecs[1] = '{12'hFFE, 4, 1'b0, 0, 3, 7};
    vecs[2] = '{12'h000, 0, 1'b0, 0, -1, 1};
    vecs[3] = '{12'h040, 8, 1'b1, 0, -1, -1};
    vecs[4] = '{12'h100, 6, 1'b0, 3, 3, 9};
    vecs[5] = '{12'h7F0, 16, 1'b0, 0, 3, 19};
    vecs[6] = '{12'hFFF, 1, 1'b0, 0, 3, 4};
    vecs[7] = '{12'h800, 4096, 1'b0, 0, 3, 4099};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Abort a 16-word burst by pulling reset low in cycle 6.
    @(posedge clk);
    #1;
    rx0 = rx_data.size();
    dc0 = done_cnt;
    cyc0 = cyc;
    start = 1'b1;
    base_addr = 12'h300;
    length = 13'd16;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cycle", cyc - cyc0, 7);
    chk_idle_outputs("abort");
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - dc0, 0);
    late = 0;
    for (int i = rx0; i < rx_data.size(); i++) if (rx_cyc[i] >= 7) late++;
    chk("abort_no_late_words", late, 0);
    chk("abort_words_before", rx_data.size() - rx0, 4);

    clean = '{12'h310, 5, 1'b0, 0, 3, 8};
    run_burst(clean);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
